// File: rtl/shift_sequencer_8bit.sv
// shift_sequencer_8bit
// Command-level sequencer for an external 8-bit shift register. It takes a
// (value, direction, amount) command, loads the register, lets it shift for
// the requested number of edges, and returns the captured result. An optional
// checker compares that result against the ideal shift.
module shift_sequencer_8bit #(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  // command channel
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_data,
  input  logic       cmd_left,
  input  logic [2:0] cmd_amount,
  // shift register controls
  output logic       sr_load_en,
  output logic       sr_shift_left,
  output logic [7:0] sr_data,
  input  logic [7:0] sr_q,
  // result channel
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [2:0] amount;
  logic [7:0] expected;
  logic       mismatch;

  // Handshake and register controls are decoded straight from the state
  // register, so no input ever reaches an output combinationally.
  assign cmd_ready  = (state == IDLE);
  assign res_valid  = (state == DONE);
  assign sr_load_en = (state == LOAD);

  // Ideal zero-filled shift of the latched command, used by the checker.
  always_comb begin
    expected = 8'h00;
    if (sr_shift_left) begin
      expected = sr_data << amount;
    end else begin
      expected = sr_data >> amount;
    end
  end

  // The comparison is only wired in when checking is enabled.
  assign mismatch = CHECK_EN ? (sr_q != expected) : 1'b0;

  // Sequencer: accept, load for one cycle, count shifts, capture, hand off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 3'd0;
      amount        <= 3'd0;
      sr_data       <= 8'h00;
      sr_shift_left <= 1'b0;
      res_data      <= 8'h00;
      res_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            sr_data       <= cmd_data;
            sr_shift_left <= cmd_left;
            amount        <= cmd_amount;
            state         <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= 3'd0;
          state <= RUN;
        end
        RUN: begin
          if (cnt == amount) begin
            res_data <= sr_q;
            res_err  <= mismatch;
            state    <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        DONE: begin
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/shift_sequencer_8bit.md
# shift_sequencer_8bit

Command-level sequencer sitting directly upstream of the 8-bit shift register. It accepts a shift command (value, direction, amount) over a valid/ready handshake and drives the register's parallel load and direction controls. It captures the register output after exactly the requested number of shifts and returns the result over a second valid/ready handshake. An optional checker compares the captured value against an internally computed expected shift and flags mismatches.

## Interface
- CHECK_EN, default 1: 1 = compare the captured result against the expected value and drive res_err; 0 = res_err tied to 0.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command; high only in IDLE.
- cmd_data  input  8  value to shift.
- cmd_left  input  1  1 = shift left, 0 = shift right.
- cmd_amount  input  3  number of 1-bit shifts, 0..7.
- sr_load_en  output  1  to shift register load_en.
- sr_shift_left  output  1  to shift register shift_left.
- sr_data  output  8  to shift register data_in.
- sr_q  input  8  from shift register data_out.
- res_valid  output  1  result available; high only in DONE.
- res_ready  input  1  consumer accepts the result.
- res_data  output  8  captured shifted value.
- res_err  output  1  captured value differs from expected (CHECK_EN=1 only).

## Operation
- States: IDLE, LOAD, RUN, DONE; 3-bit count register cnt.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_data, cmd_left and cmd_amount, then go to LOAD.
- sr_data and sr_shift_left are registered copies of the latched data and direction. They update on acceptance and hold until the next acceptance.
- LOAD: sr_load_en=1 for exactly one cycle. Clear cnt to 0 and go to RUN.
- RUN: sr_load_en=0, so the register shifts once per edge in the latched direction.
  - If cnt==amount: res_data<=sr_q, res_err<=(sr_q!=expected), go to DONE.
  - Otherwise cnt<=cnt+1.
- Expected value: left = (data<<amount) truncated to 8 bits, zero-filled; right = data>>amount, zero-filled.
- DONE: res_valid=1. res_data and res_err stay stable until res_valid&&res_ready, then go to IDLE.
- The shift register free-runs while the sequencer is in IDLE/DONE. Its contents there are don't-care. The sequencer never samples sr_q outside RUN.
- cmd_valid is ignored outside IDLE; a command is never accepted in the same cycle a result is returned.
- Reset (any state, any time) returns to IDLE. Reset values:
  - cmd_ready=1, res_valid=0, res_data=0x00, res_err=0.
  - sr_load_en=0, sr_shift_left=0, sr_data=0x00, cnt=0.
- A command in flight when reset asserts is discarded and no result is produced.

## Timing
- Accept on edge E0. LOAD during cycle E0–E1; the register holds data after E1.
- RUN starts after E1 (cnt=0, sr_q=data).
- Capture on edge E(2+amount); res_valid is high from that edge.
- Latency from accept edge to res_valid: amount+2 cycles (2 for amount 0, 9 for amount 7).
- If res_ready is already high, res_valid lasts 1 cycle and cmd_ready rises on the next edge.
- Minimum command period: amount+4 cycles.
- sr_load_en is never high in two consecutive cycles and is high exactly once per command.
- All outputs are registered or decoded directly from the state register. There is no combinational path from any input to any output.

## Test plan
- Reset then idle 10 cycles: cmd_ready=1, res_valid=0, res_data=0x00, res_err=0, sr_load_en=0 throughout.
- Command 0xB5, left, amount 3, res_ready=1: res_valid 5 cycles after accept, res_data=0xA8, res_err=0. Then 0xB5 right 3: res_data=0x16.
- Amount 0 (0x5A left): res_valid 2 cycles after accept, res_data=0x5A. Then 0xFF left 7: res_valid 9 cycles after accept, res_data=0x80.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid:
  - res_valid, res_data and res_err stay stable.
  - cmd_ready stays 0 and a cmd_valid pulse is not accepted.
  - Release res_ready: cmd_ready=1 one cycle later.
- Assert rst during RUN (amount 6, cnt=3): all outputs return to reset values immediately. No result appears afterwards, and the next command completes correctly.
- Error injection (CHECK_EN=1): bench substitutes a register model that fails to shift once. 0xB5 left 3 gives res_err=1. With CHECK_EN=0, res_err=0.
